// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-port FIFOs drained round-robin onto one ready/valid scoreboard port.
// Optional zero-latency bypass when WB_ARB_BYPASS_EN is defined.
module wb_arbiter #(
  parameter int unsigned NR_PORTS      = 4,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned EXC_BITS      = 8,
  localparam int unsigned PORT_W       = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NR_PORTS-1:0]               wb_valid_i,
  input  logic [NR_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [NR_PORTS*XLEN-1:0]          wb_result_i,
  input  logic [NR_PORTS*EXC_BITS-1:0]      wb_exception_i,
  output logic [NR_PORTS-1:0]               wb_almost_full_o,
  output logic                              sb_valid_o,
  input  logic                              sb_ready_i,
  output logic [TRANS_ID_BITS-1:0]          sb_trans_id_o,
  output logic [XLEN-1:0]                   sb_result_o,
  output logic [EXC_BITS-1:0]               sb_exception_o,
  output logic [PORT_W-1:0]                 sb_port_o,
  output logic [NR_PORTS-1:0]               overflow_o
);

  localparam int unsigned ENTRY_W = TRANS_ID_BITS + XLEN + EXC_BITS;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  logic [ENTRY_W-1:0]  mem_q    [NR_PORTS][DEPTH];
  logic [ENTRY_W-1:0]  mem_d    [NR_PORTS][DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q [NR_PORTS];
  logic [PTR_W-1:0]    wr_ptr_d [NR_PORTS];
  logic [PTR_W-1:0]    rd_ptr_q [NR_PORTS];
  logic [PTR_W-1:0]    rd_ptr_d [NR_PORTS];
  logic [CNT_W-1:0]    cnt_q    [NR_PORTS];
  logic [CNT_W-1:0]    cnt_d    [NR_PORTS];
  logic [PORT_W-1:0]   rr_q, rr_d;
  logic [PORT_W-1:0]   lock_port_q, lock_port_d;
  logic                lock_q, lock_d;
  logic [NR_PORTS-1:0] overflow_q, overflow_d;

  logic [ENTRY_W-1:0]  in_entry [NR_PORTS];
  logic [NR_PORTS-1:0] not_empty;
  logic [PORT_W-1:0]   gnt;
  logic                gnt_valid;
  logic [ENTRY_W-1:0]  gnt_entry;
  logic                bypass;
  logic                handshake;
  logic                found;
  int unsigned         idx;

  always_comb begin
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      in_entry[p]  = {wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS],
                      wb_result_i[p*XLEN +: XLEN],
                      wb_exception_i[p*EXC_BITS +: EXC_BITS]};
      not_empty[p] = (cnt_q[p] != '0);
    end
  end

  // A held lock pins the grant so late arrivals cannot reshuffle a stalled writeback.
  always_comb begin
    gnt       = rr_q;
    found     = 1'b0;
    idx       = 0;
    bypass    = 1'b0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      idx = (32'(rr_q) + i) % NR_PORTS;
      if (!found && not_empty[idx]) begin
        gnt   = PORT_W'(idx);
        found = 1'b1;
      end
    end
    if (lock_q) gnt = lock_port_q;
    gnt_valid = |not_empty;
    gnt_entry = mem_q[gnt][rd_ptr_q[gnt]];
`ifdef WB_ARB_BYPASS_EN
    if (!gnt_valid && !lock_q && !flush_i && (|wb_valid_i)) begin
      found = 1'b0;
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
        idx = (32'(rr_q) + i) % NR_PORTS;
        if (!found && wb_valid_i[idx]) begin
          gnt   = PORT_W'(idx);
          found = 1'b1;
        end
      end
      gnt_valid = 1'b1;
      gnt_entry = in_entry[gnt];
      bypass    = 1'b1;
    end
`endif
    handshake = gnt_valid && sb_ready_i;
  end

  assign sb_valid_o = gnt_valid;
  assign {sb_trans_id_o, sb_result_o, sb_exception_o} = gnt_valid ? gnt_entry : '0;
  assign sb_port_o  = gnt_valid ? gnt : '0;
  assign overflow_o = overflow_q;

  always_comb begin
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      wb_almost_full_o[p] = (cnt_q[p] >= CNT_W'(DEPTH - 1));
    end
  end

  // A pop frees the slot the simultaneous push lands in, so a full FIFO still accepts it.
  always_comb begin
    logic pop, push, push_ok;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    rr_d        = rr_q;
    lock_d      = gnt_valid && !sb_ready_i;
    lock_port_d = gnt;
    pop         = 1'b0;
    push        = 1'b0;
    push_ok     = 1'b0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      pop     = handshake && !bypass && (gnt == PORT_W'(p));
      push    = wb_valid_i[p] && !(handshake && bypass && (gnt == PORT_W'(p)));
      push_ok = push && ((cnt_q[p] != CNT_W'(DEPTH)) || pop);
      if (pop) rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
      if (push_ok) begin
        mem_d[p][wr_ptr_q[p]] = in_entry[p];
        wr_ptr_d[p]           = wr_ptr_q[p] + 1'b1;
      end else if (push) begin
        overflow_d[p] = 1'b1;
      end
      cnt_d[p] = cnt_q[p] + CNT_W'(push_ok) - CNT_W'(pop);
    end
    if (handshake) rr_d = PORT_W'((32'(gnt) + 1) % NR_PORTS);
    if (flush_i) begin
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        wr_ptr_d[p] = '0;
        rd_ptr_d[p] = '0;
        cnt_d[p]    = '0;
      end
      overflow_d = overflow_q;
      rr_d       = '0;
      lock_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
      overflow_q  <= '0;
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
